mult_issue: RTL and testbench

Upstream front end for the sequential repeated-addition multiplier (controller plus datapath). Accepts operand pairs over a valid/ready request port and drives the controller's `start` input and the datapath's shared operand bus: A first, then B. It waits for `done`, captures the product, and returns it over a valid/ready response port. It also short-circuits zero operands and enforces a watchdog timeout.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_wdog.sv | 32 +++
 rtl/mult_issue.sv | 121 ++++++++++++
 tb/tb_mult_issue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the repeated-addition multiplier front end.
package mult_pkg;

  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = (2 ** W_DEF) + 8;

  // Sequencer state encoding, shared with anything that observes the issue FSM
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Product width for a given operand width
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_wdog.sv
// Clearable up-counter with terminal-count flag, bounding how long the
// issue block waits for the multiplier's done.
module mult_wdog #(
  parameter int TIMEOUT = 264
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

  // Count while enabled; park at terminal count so the value never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mult_issue.sv
// Front end for the sequential multiplier: takes an operand pair, presents
// A then B on the shared bus while holding start, waits for done (or the
// watchdog), and returns the product over a valid/ready response port.
module mult_issue
  import mult_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [W-1:0]           req_a,
  input  logic [W-1:0]           req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [prod_w(W)-1:0]   rsp_prod,
  output logic                   rsp_err,
  output logic                   start,
  output logic [W-1:0]           data_out,
  input  logic                   done,
  input  logic [prod_w(W)-1:0]   prod_in
);

  localparam int PW = prod_w(W);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            err_q, err_d;
  logic            wd_clr, wd_en, wd_tc;

  mult_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  // Next-state, operand latch and result capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d = req_a;
          b_d = req_b;
          if (req_a == '0 || req_b == '0) begin
            // Zero operand: the multiplier is never started
            prod_d  = '0;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // done wins over a timeout landing in the same cycle
        if (done) begin
          prod_d  = prod_in;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_tc) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode only registered state/operands, so start and the bus
  // never see req_* or done combinationally.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_prod  = prod_q;
    rsp_err   = err_q;
    start     = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B) ||
                (state_q == ST_WAIT);
    data_out  = '0;
    if (state_q == ST_LOAD_A)      data_out = a_q;
    else if (state_q == ST_LOAD_B) data_out = b_q;
  end

endmodule

// File: tb/tb_mult_issue.sv
// Bench for mult_issue with a behavioural controller+datapath model that
// captures A and B from the bus and raises done after b+1 WAIT cycles.
module tb_mult_issue;

  localparam int W  = 8;
  localparam int TO = 264;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_a = '0;
  logic [7:0]    req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [15:0]   rsp_prod;
  logic          rsp_err;
  logic          start;
  logic [7:0]    data_out;
  logic          done = 1'b0;
  logic [15:0]   prod_in = '0;

  int checks = 0;
  int errors = 0;

  mult_issue #(.W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .start     (start),
    .data_out  (data_out),
    .done      (done),
    .prod_in   (prod_in)
  );

  always #5 clk = ~clk;

  // Controller+datapath model: first start cycle captures A, second B,
  // then b iterations of accumulation before done; drops back when start falls.
  logic [1:0] ph = '0;
  logic [7:0] ma = '0, mb = '0;
  logic [8:0] mcnt = '0;
  logic       done_en = 1'b1;
  always @(posedge clk) begin
    if (reset || !start) begin
      ph <= '0; done <= 1'b0; mcnt <= '0;
    end else if (ph == 2'd0) begin
      ma <= data_out; ph <= 2'd1;
    end else if (ph == 2'd1) begin
      mb <= data_out; mcnt <= '0; ph <= 2'd2;
    end else if (done_en && !done && (mcnt == {1'b0, mb} - 9'd1)) begin
      done <= 1'b1; prod_in <= {8'd0, ma} * {8'd0, mb};
    end else if (!done) begin
      mcnt <= mcnt + 9'd1;
    end
  end

  // Issue one request from a negedge and follow it to RESP (left unacked)
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output logic e, output int lat,
                        output int starts, output logic [7:0] ba,
                        output logic [7:0] bb, output bit stale);
    bit dprev;
    req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; starts = 0; ba = '0; bb = '0; stale = 1'b0; dprev = 1'b0;
    while (!rsp_valid && lat < 400) begin
      if (start) begin
        starts++;
        if (starts == 1) ba = data_out;
        else if (starts == 2) bb = data_out;
      end
      if (dprev && start) stale = 1'b1;
      dprev = done;
      @(negedge clk);
      lat++;
    end
    if (dprev && start) stale = 1'b1;
    p = rsp_prod; e = rsp_err;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_prod !== 16'd0) begin errors++; $display("FAIL reset_rsp_prod got %0d want 0", rsp_prod); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start); end
    checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL reset_data_out got %0d want 0", data_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    run_op(8'd6, 8'd7, p, e, lat, st, ba, bb, stale);
    checks++; if (p !== 16'd42) begin errors++; $display("FAIL basic_prod got %0d want 42", p); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", e); end
    checks++; if (st !== 10) begin errors++; $display("FAIL basic_start_cycles got %0d want 10", st); end
    checks++; if (ba !== 8'd6) begin errors++; $display("FAIL basic_bus_a got %0d want 6", ba); end
    checks++; if (bb !== 8'd7) begin errors++; $display("FAIL basic_bus_b got %0d want 7", bb); end
    checks++; if (lat !== 11) begin errors++; $display("FAIL basic_latency got %0d want 11", lat); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL basic_start_after_done got %b want 0", stale); end
    ack();
  endtask

  task automatic test_zero();
    logic [7:0] as [2] = '{8'd0, 8'd9};
    logic [7:0] bs [2] = '{8'd200, 8'd0};
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    for (int i = 0; i < 2; i++) begin
      run_op(as[i], bs[i], p, e, lat, st, ba, bb, stale);
      checks++; if (st !== 0) begin errors++; $display("FAIL zero%0d_start got %0d want 0", i, st); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL zero%0d_latency got %0d want 1", i, lat); end
      checks++; if (p !== 16'd0 || e !== 1'b0) begin errors++; $display("FAIL zero%0d_result got %0d/%b want 0/0", i, p, e); end
      ack();
    end
  endtask

  task automatic test_max();
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    run_op(8'd255, 8'd255, p, e, lat, st, ba, bb, stale);
    checks++; if (p !== 16'd65025) begin errors++; $display("FAIL max_prod got %0d want 65025", p); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL max_err got %b want 0", e); end
    checks++; if (lat !== 259) begin errors++; $display("FAIL max_latency got %0d want 259", lat); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL max_start_after_done got %b want 0", stale); end
    ack();
  endtask

  task automatic test_timeout();
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    done_en = 1'b0;
    run_op(8'd3, 8'd4, p, e, lat, st, ba, bb, stale);
    checks++; if (lat !== TO + 3) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, TO + 3); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", e); end
    checks++; if (p !== 16'd0) begin errors++; $display("FAIL timeout_prod got %0d want 0", p); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL timeout_start_in_resp got %b want 0", start); end
    done_en = 1'b1;
    ack();
  endtask

  task automatic test_back_to_back();
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    run_op(8'd3, 8'd5, p, e, lat, st, ba, bb, stale);
    checks++; if (p !== 16'd15) begin errors++; $display("FAIL b2b_first_prod got %0d want 15", p); end
    req_a = 8'd1; req_b = 8'd1; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_prod !== 16'd15)
        begin errors++; $display("FAIL hold%0d got v=%b rdy=%b p=%0d want 1/0/15", i, rsp_valid, req_ready, rsp_prod); end
    end
    req_valid = 1'b0;
    ack();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_after_ack got %b want 1", req_ready); end
    run_op(8'd12, 8'd10, p, e, lat, st, ba, bb, stale);
    checks++; if (p !== 16'd120 || e !== 1'b0) begin errors++; $display("FAIL b2b_second got %0d/%b want 120/0", p, e); end
    checks++; if (lat !== 14) begin errors++; $display("FAIL b2b_second_latency got %0d want 14", lat); end
    ack();
  endtask

  task automatic test_reset_mid();
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    req_a = 8'd5; req_b = 8'd9; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL midreset got start=%b v=%b rdy=%b want 0/0/1", start, rsp_valid, req_ready); end
    run_op(8'd2, 8'd2, p, e, lat, st, ba, bb, stale);
    checks++; if (p !== 16'd4 || e !== 1'b0) begin errors++; $display("FAIL midreset_next got %0d/%b want 4/0", p, e); end
    ack();
  endtask

  task automatic test_random();
    logic [15:0] p; logic e; int lat, st; logic [7:0] ba, bb; bit stale;
    logic [7:0] a, b; int exp_lat;
    for (int i = 0; i < 10; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      exp_lat = (a == 0 || b == 0) ? 1 : int'(b) + 4;
      run_op(a, b, p, e, lat, st, ba, bb, stale);
      checks++;
      if (p !== 16'(int'(a) * int'(b)) || e !== 1'b0 || lat !== exp_lat)
        begin errors++; $display("FAIL rand%0d a=%0d b=%0d got %0d/%b/lat%0d want %0d/0/lat%0d", i, a, b, p, e, lat, int'(a) * int'(b), exp_lat); end
      ack();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
